coherence_controller: RTL

Shared memory-bus controller for the dual-core system. It sits between the two cores' icaches/dcaches (via the `cc` side of `cache_control_if`) and the single-ported RAM. It arbitrates word-granular instruction and data accesses, and it sequences the MSI snoop handshake, including cache-to-cache forwarding of dirty data with simultaneous writeback to RAM.

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/cache_control_if.sv | 21 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/coherence_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the dual-core memory system.
//   word_t      32-bit bus word
//   ramstate_t  RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   cc_state_t  coherence controller FSM states
//   CC_PRIO_*   arbitration class indices, lower index = higher priority
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IFETCH = 3'd1,
      RAMRD  = 3'd2,
      RAMWR  = 3'd3,
      SNOOP  = 3'd4,
      C2C    = 3'd5,
      INVAL  = 3'd6
   } cc_state_t;

   localparam int CC_PRIO_WB  = 0;  // dWEN writeback
   localparam int CC_PRIO_SNP = 1;  // dREN with cctrans
   localparam int CC_PRIO_RD  = 2;  // plain dREN
   localparam int CC_PRIO_UPG = 3;  // S->M upgrade, no data transfer
   localparam int CC_PRIO_IF  = 4;  // instruction fetch
   localparam int CC_NCLS     = 5;

   // Transaction state entered when a class wins arbitration in IDLE.
   function automatic cc_state_t cls2state(input logic [2:0] cls);
      case (cls)
         3'(CC_PRIO_WB):  return RAMWR;
         3'(CC_PRIO_SNP): return SNOOP;
         3'(CC_PRIO_RD):  return RAMRD;
         3'(CC_PRIO_UPG): return INVAL;
         3'(CC_PRIO_IF):  return IFETCH;
         default:         return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/cache_control_if.sv
// cache_control_if: bundle between the caches, the coherence controller and RAM.
//   cc modport: controller view (cache requests + RAM status in, waits/loads/
//   snoop controls + RAM request out).
interface cache_control_if #(parameter int CPUS = 2);
   import cpu_types_pkg::*;

   logic [CPUS-1:0]        iREN, dREN, dWEN, ccwrite, cctrans;
   word_t [CPUS-1:0]       iaddr, daddr, dstore;
   logic [CPUS-1:0]        iwait, dwait, ccwait, ccinv;
   word_t [CPUS-1:0]       iload, dload, ccsnoopaddr;
   word_t                  ramload, ramaddr, ramstore;
   ramstate_t              ramstate;
   logic                   ramREN, ramWEN;

   modport cc (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans,
      input  ramload, ramstate,
      output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
      output ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin pick.
//   req[1:0]    request per core
//   last_grant  core served by the previous completed transaction
//   gnt         chosen core (valid only when vld)
//   vld         any request present
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt,
   output logic       vld
);
   // On a tie the core that was not served last wins; otherwise the lone requester.
   assign gnt = (&req) ? ~last_grant : req[1];
   assign vld = |req;
endmodule

// File: rtl/coherence_controller.sv
// coherence_controller: shared RAM arbiter and MSI snoop sequencer for two cores.
//   CLK   system clock (rising edge)
//   nRST  asynchronous active-low reset
//   ccif  cache_control_if.cc: cache requests/snoop replies and RAM status in;
//         wait/load/snoop controls to the caches and RAM request out.
// All outputs are combinational from {state, grant, last_grant} and the inputs.
module coherence_controller
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   cache_control_if.cc      ccif
);

   if (CPUS != 2) begin : g_cpus_chk
      $error("coherence_controller: snoop logic supports exactly 2 CPUs");
   end

   cc_state_t  state, state_nxt;
   logic       grant, grant_nxt;
   logic       last_grant, last_grant_nxt;
   logic       i, j;
   logic       done;
   logic [2:0] sel;

   logic [CC_NCLS-1:0][1:0] cls_req;
   logic [CC_NCLS-1:0]      cls_gnt, cls_vld;

   assign i = grant;
   assign j = ~grant;

   // Per-class request vectors; a core's upgrade only counts with no data request pending.
   always_comb begin
      cls_req = '0;
      for (int c = 0; c < 2; c++) begin
         cls_req[CC_PRIO_WB][c]  = ccif.dWEN[c];
         cls_req[CC_PRIO_SNP][c] = ccif.dREN[c] & ccif.cctrans[c];
         cls_req[CC_PRIO_RD][c]  = ccif.dREN[c] & ~ccif.cctrans[c];
         cls_req[CC_PRIO_UPG][c] = ccif.cctrans[c] & ccif.ccwrite[c]
                                   & ~ccif.dREN[c] & ~ccif.dWEN[c];
         cls_req[CC_PRIO_IF][c]  = ccif.iREN[c];
      end
   end

   for (genvar k = 0; k < CC_NCLS; k++) begin : g_arb
      rr_arbiter2 u_arb (
         .req        (cls_req[k]),
         .last_grant (last_grant),
         .gnt        (cls_gnt[k]),
         .vld        (cls_vld[k])
      );
   end

   // Highest-priority valid class (lowest index).
   always_comb begin
      sel = 3'(CC_PRIO_IF);
      for (int k = CC_NCLS-1; k >= 0; k--)
         if (cls_vld[k]) sel = 3'(k);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      grant_nxt        = grant;
      last_grant_nxt   = last_grant;
      done             = 1'b0;
      ccif.iwait       = '1;
      ccif.dwait       = '1;
      ccif.ccwait      = '0;
      ccif.ccinv       = '0;
      ccif.iload       = '0;
      ccif.dload       = '0;
      ccif.ccsnoopaddr = '0;
      ccif.ramREN      = 1'b0;
      ccif.ramWEN      = 1'b0;
      ccif.ramaddr     = '0;
      ccif.ramstore    = '0;

      case (state)
         IDLE: begin
            if (|cls_vld) begin
               state_nxt = cls2state(sel);
               grant_nxt = cls_gnt[sel];
            end
         end
         IFETCH: begin
            ccif.ramREN   = 1'b1;
            ccif.ramaddr  = ccif.iaddr[i];
            ccif.iload[i] = ccif.ramload;
            if (ccif.ramstate == ACCESS) begin
               ccif.iwait[i] = 1'b0;
               done          = 1'b1;
            end
         end
         RAMRD: begin
            ccif.ramREN   = 1'b1;
            ccif.ramaddr  = ccif.daddr[i];
            ccif.dload[i] = ccif.ramload;
            if (ccif.ramstate == ACCESS) begin
               ccif.dwait[i] = 1'b0;
               done          = 1'b1;
            end
         end
         RAMWR: begin
            ccif.ramWEN   = 1'b1;
            ccif.ramaddr  = ccif.daddr[i];
            ccif.ramstore = ccif.dstore[i];
            if (ccif.ramstate == ACCESS) begin
               ccif.dwait[i] = 1'b0;
               done          = 1'b1;
            end
         end
         SNOOP: begin
            ccif.ccwait[j]      = 1'b1;
            ccif.ccsnoopaddr[j] = ccif.daddr[i];
            ccif.ccinv[j]       = ccif.ccwrite[i];
            // Snooped cache flags a Modified copy by raising ccwrite this cycle.
            state_nxt = ccif.ccwrite[j] ? C2C : RAMRD;
         end
         C2C: begin
            // Dirty line goes to the requester and to RAM in the same beat.
            ccif.ccwait[j]      = 1'b1;
            ccif.ccsnoopaddr[j] = ccif.daddr[i];
            ccif.ramWEN         = 1'b1;
            ccif.ramaddr        = ccif.daddr[i];
            ccif.ramstore       = ccif.dstore[j];
            ccif.dload[i]       = ccif.dstore[j];
            if (ccif.ramstate == ACCESS) begin
               ccif.dwait[i] = 1'b0;
               ccif.dwait[j] = 1'b0;
               done          = 1'b1;
            end
         end
         INVAL: begin
            ccif.ccwait[j]      = 1'b1;
            ccif.ccinv[j]       = 1'b1;
            ccif.ccsnoopaddr[j] = ccif.daddr[i];
            ccif.dwait[i]       = 1'b0;
            done                = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (done) begin
         state_nxt      = IDLE;
         last_grant_nxt = grant;
      end
   end

endmodule
